range_tracker: RTL
==================

# range_tracker

Parametrised successor to the single-shot range finder: tracks running maximum, minimum and range of a sample stream between a `go` and a `finish` strobe. Adds a per-sample valid qualifier, signed/unsigned compare mode, a saturating sample counter, registered results held until the next run, and a one-cycle completion pulse. Sits between the input sample register and the result/readout logic in the measurement datapath.

## Interface
- `WIDTH`, 16: sample width in bits, ≥2.
- `CNT_WIDTH`, 8: sample counter width, ≥1.
- `SIGNED`, 0: 1 = two's-complement compare, 0 = unsigned compare.

- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock, synchronous active-high reset.
- `data_in`  in  WIDTH  sample.
- `data_valid`  in  1  qualifies `data_in` in TRACK.
- `go`  in  1  start a run; `data_in` on this cycle is the first sample (no `data_valid` needed).
- `finish`  in  1  end the run.
- `max_out`  out  WIDTH  registered maximum of the last completed run.
- `min_out`  out  WIDTH  registered minimum of the last completed run.
- `range`  out  WIDTH  registered `max_out - min_out`, always unsigned.
- `count`  out  CNT_WIDTH  samples in last completed run, saturating.
- `busy`  out  1  high in TRACK.
- `done`  out  1  one-cycle pulse when results update.
- `debug_error`  out  1  one-cycle registered pulse on illegal strobe.

## Operation
- States: IDLE, TRACK, DONE. Reset → IDLE; all outputs and internal registers 0.
- IDLE:
  - `finish`=1, whether or not `go`=1: stay IDLE, pulse `debug_error`.
  - `go`=1, `finish`=0: load working max/min with `data_in`, working count ← 1, go to TRACK.
  - Otherwise: stay.
- TRACK:
  - `data_valid`=1: update working max if `data_in` > max, working min if `data_in` < min.
    - Both updates are evaluated independently; a sample may update both.
    - Working count += 1, saturating at 2^CNT_WIDTH−1.
  - `finish`=1: go to DONE. A valid sample on the `finish` cycle is included.
  - `go`=1: ignored, and pulses `debug_error`. Combined with `finish`=1: `finish` is still honoured and the error still pulses.
- DONE (one cycle):
  - Copy working max/min/count to `max_out`/`min_out`/`count`; `range` ← max − min in WIDTH bits.
  - Inputs are ignored; return to IDLE.
- Compare mode: `SIGNED`=1 uses signed comparison. Range is computed modulo 2^WIDTH and interpreted unsigned; it never overflows.
- Result outputs hold until the next DONE. A new run does not clear them.

## Timing
- `go` accepted at edge N: `busy`=1 from N+1.
- `finish` at edge M (in TRACK): DONE during cycle M+1.
  - Results, `range` and `done`=1 are visible from edge M+2 for exactly one cycle (`done`).
  - `busy`=0 from M+1.
- `debug_error` is asserted the cycle after the offending edge, for one cycle.
- Minimum run: `go` at N, `finish` at N+1, `done` visible after N+3.
- `reset` overrides everything on the same edge, including mid-TRACK and mid-DONE. Held results are also cleared to 0.

## Configuration
- `RANGE_TRACKER_COUNT_EN` defined: working counter and `count` register present, behaviour as above.
- Not defined: no counter logic; `count` tied to 0. All other behaviour is identical.

## Test plan
- Unsigned, WIDTH=16. `go` with 0x0010, then valid 0x0005, 0x0040, 0x0020, `finish` with 0x0030 valid → `max_out`=0x0040, `min_out`=0x0005, `range`=0x003B, `count`=5, `done` one cycle.
- SIGNED=1, WIDTH=8. `go` with 0x05, valid 0xF0 (−16), 0x7F, `finish` → `max_out`=0x7F, `min_out`=0xF0, `range`=0x8F.
- Invalid samples are ignored: `go` 10; 99 with `data_valid`=0; 3 valid; `finish` → `max_out`=10, `min_out`=3, `count`=2.
- Illegal strobes:
  - `finish` in IDLE → `debug_error` pulse, `busy` stays 0.
  - `go`+`finish` in IDLE → same.
  - `go` in TRACK → error pulse, run continues and results are unaffected.
- Saturation and config: CNT_WIDTH=2, 6 valid samples → `count`=3. Without `RANGE_TRACKER_COUNT_EN` → `count`=0.
- Reset mid-TRACK after a completed run → all outputs 0 next cycle, state IDLE. A following `go` 7 / `finish` → max=min=7, `range`=0.

Source files
------------

// File: rtl/range_tracker.sv
// range_tracker: running max/min/range/count of a qualified sample stream between go and finish strobes
//   Build option: define RANGE_TRACKER_COUNT_EN to include the saturating sample counter (count tied to 0 otherwise).
//   Parameters: WIDTH sample width, CNT_WIDTH counter width, SIGNED 1 = two's-complement compare.
//   Inputs : clock, reset (sync, active-high), data_in, data_valid, go, finish.
//   Outputs: max_out, min_out, range, count (held results of the last run), busy, done, debug_error.
module range_tracker #(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 8,
  parameter int SIGNED    = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 data_valid,
  input  logic                 go,
  input  logic                 finish,
  output logic [WIDTH-1:0]     max_out,
  output logic [WIDTH-1:0]     min_out,
  output logic [WIDTH-1:0]     range,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 busy,
  output logic                 done,
  output logic                 debug_error
);
  typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;
  state_t state, next;
  logic [WIDTH-1:0] wmax, wmin;
  logic start, err, gt_max, lt_min, upd;
  assign gt_max = (SIGNED != 0) ? ($signed(data_in) > $signed(wmax)) : (data_in > wmax);
  assign lt_min = (SIGNED != 0) ? ($signed(data_in) < $signed(wmin)) : (data_in < wmin);
  assign upd    = (state == TRACK) && data_valid;
  assign busy   = (state == TRACK);
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next  = state;
    start = 1'b0;
    err   = 1'b0;
    case (state)
      IDLE: begin
        err   = finish;
        start = go && !finish;
        next  = start ? TRACK : IDLE;
      end
      TRACK: begin
        err  = go;
        next = finish ? DONE : TRACK;
      end
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      wmax        <= '0;
      wmin        <= '0;
      max_out     <= '0;
      min_out     <= '0;
      range       <= '0;
      done        <= 1'b0;
      debug_error <= 1'b0;
    end else begin
      done        <= 1'b0;
      debug_error <= err;
      if (start) begin
        wmax <= data_in;
        wmin <= data_in;
      end else if (upd) begin
        if (gt_max) wmax <= data_in;
        if (lt_min) wmin <= data_in;
      end
      if (state == DONE) begin
        max_out <= wmax;
        min_out <= wmin;
        // modular subtraction: always fits WIDTH bits and is read as unsigned
        range   <= wmax - wmin;
        done    <= 1'b1;
      end
    end
`ifdef RANGE_TRACKER_COUNT_EN
  logic [CNT_WIDTH-1:0] wcnt;
  always_ff @(posedge clock)
    if (reset) begin
      wcnt  <= '0;
      count <= '0;
    end else begin
      if (start) wcnt <= CNT_WIDTH'(1);
      else if (upd && wcnt != '1) wcnt <= wcnt + CNT_WIDTH'(1);
      if (state == DONE) count <= wcnt;
    end
`else
  assign count = '0;
`endif
endmodule
